// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants and types for the microwave countdown timer digits.
//   DIGIT_W : bit width of one BCD-style timer digit
//   MOD6    : modulus of the tens-of-seconds digit
//   MOD10   : modulus of the units digit
//   digit_t : one timer digit value
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam int MOD6    = 6;
  localparam int MOD10   = 10;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage : timer_pkg

// File: rtl/mod_n_down_core.sv
// ---------------------------------------------------------------------------
// mod_n_down_core
// Loadable modulo-N down-counter register shared by all timer digits.
// Handles clear, load with saturation, and decrement with wrap (or hold at
// zero when STOP_AT_ZERO is set).
// Parameters:
//   MODULUS      : count range 0..MODULUS-1 (2..16)
//   WIDTH        : register width; MODULUS-1 must fit
//   STOP_AT_ZERO : 1 = decrement at 0 holds at 0, 0 = wraps to MODULUS-1
// Ports:
//   clk      in   rising-edge clock
//   Cn       in   synchronous active-low clear
//   Cin      in   synchronous active-low load strobe
//   z        in   active-high decrement enable
//   i_load   in   preset value for load
//   o_count  out  registered counter value
// ---------------------------------------------------------------------------
module mod_n_down_core
  import timer_pkg::*;
#(
  parameter int MODULUS      = MOD6,
  parameter int WIDTH        = DIGIT_W,
  parameter bit STOP_AT_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             Cn,
  input  logic             Cin,
  input  logic             z,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_loadValue;
  logic [WIDTH-1:0] w_decValue;

  // Load value: presets above the top of the range saturate to MODULUS-1
  // so an illegal preset can never put the digit out of range.
  always_comb begin
    w_loadValue = i_load;
    if (i_load > MAX_VAL) begin
      w_loadValue = MAX_VAL;
    end
  end

  // Decrement value: step down by one, wrap (or stick) at zero. A register
  // that is somehow above the range, e.g. an unreset power-up state, is
  // pulled back to MODULUS-1 by the next decrement.
  always_comb begin
    w_decValue = r_count - 1'b1;
    if (r_count == '0) begin
      w_decValue = STOP_AT_ZERO ? '0 : MAX_VAL;
    end else if (r_count > MAX_VAL) begin
      w_decValue = MAX_VAL;
    end
  end

  // Counter register with priority clear > load > decrement > hold.
  // A load cycle never also decrements, even when z is high.
  always_ff @(posedge clk) begin
    if (!Cn) begin
      r_count <= '0;
    end else if (!Cin) begin
      r_count <= w_loadValue;
    end else if (z) begin
      r_count <= w_decValue;
    end
  end

  assign o_count = r_count;

endmodule : mod_n_down_core

// File: rtl/timer_six.sv
// ---------------------------------------------------------------------------
// timer_six
// Tens-of-seconds digit (0..5) of the microwave countdown timer. Wraps the
// shared down-counter core and adds the cascade flags.
// Configuration macro:
//   TIMER_SIX_STOP_AT_ZERO_EN : when defined, a decrement at 0 holds at 0
//                               (most-significant digit of the chain);
//                               when undefined, 0 wraps to MODULUS-1.
// Ports:
//   clk   in   rising-edge clock
//   Cn    in   synchronous active-low clear
//   in    in   preset value for load
//   Cin   in   synchronous active-low load strobe
//   z     in   count enable / borrow-in from lower digit
//   out   out  registered digit value
//   x     out  borrow-out to upper digit (z & zero), combinational
//   zero  out  digit-is-zero flag, combinational
// ---------------------------------------------------------------------------
module timer_six
  import timer_pkg::*;
#(
  parameter int MODULUS = MOD6,
  parameter int WIDTH   = DIGIT_W
) (
  input  logic             clk,
  input  logic             Cn,
  input  logic [WIDTH-1:0] in,
  input  logic             Cin,
  input  logic             z,
  output logic [WIDTH-1:0] out,
  output logic             x,
  output logic             zero
);

`ifdef TIMER_SIX_STOP_AT_ZERO_EN
  localparam bit STOP_AT_ZERO = 1'b1;
`else
  localparam bit STOP_AT_ZERO = 1'b0;
`endif

  logic [WIDTH-1:0] w_count;

  mod_n_down_core #(
    .MODULUS      (MODULUS),
    .WIDTH        (WIDTH),
    .STOP_AT_ZERO (STOP_AT_ZERO)
  ) u_core (
    .clk     (clk),
    .Cn      (Cn),
    .Cin     (Cin),
    .z       (z),
    .i_load  (in),
    .o_count (w_count)
  );

  // Borrow-out is asserted in the cycle the digit is about to wrap, so the
  // upper digit decrements on the same edge this digit leaves zero.
  assign out  = w_count;
  assign zero = (w_count == '0);
  assign x    = z & zero;

endmodule : timer_six

// File: tb/tb_timer_six.sv
// ---------------------------------------------------------------------------
// tb_timer_six
// Directed self-checking bench for timer_six with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_timer_six;
  import timer_pkg::*;

  logic   clk;
  logic   Cn;
  digit_t in;
  logic   Cin;
  logic   z;
  digit_t out;
  logic   x;
  logic   zero;

  int testsRun;
  int testsFailed;

  timer_six #(
    .MODULUS (MOD6),
    .WIDTH   (DIGIT_W)
  ) dut (
    .clk  (clk),
    .Cn   (Cn),
    .in   (in),
    .Cin  (Cin),
    .z    (z),
    .out  (out),
    .x    (x),
    .zero (zero)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs, let one rising edge pass, then settle so the
  // outputs are sampled well away from the edge. Inputs stay applied so the
  // combinational flags reflect the current z.
  task automatic applyStimulus(input logic cn, input logic cin,
                               input logic zin, input digit_t val);
    Cn  = cn;
    Cin = cin;
    z   = zin;
    in  = val;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Decrement sequence after loading 3: wraps 0 -> 5.
  logic [3:0] decSeq [5];
`ifdef TIMER_SIX_STOP_AT_ZERO_EN
  logic [3:0] stopSeq [3] = '{4'd0, 4'd0, 4'd0};
  logic       stopX   [3] = '{1'b1, 1'b1, 1'b1};
`else
  logic [3:0] stopSeq [3] = '{4'd0, 4'd5, 4'd4};
  logic       stopX   [3] = '{1'b1, 1'b0, 1'b0};
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    Cn  = 1'b1;
    Cin = 1'b1;
    z   = 1'b0;
    in  = '0;
`ifdef TIMER_SIX_STOP_AT_ZERO_EN
    decSeq = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
`else
    decSeq = '{4'd2, 4'd1, 4'd0, 4'd5, 4'd4};
`endif
    @(negedge clk);

    // Clear with z high: out 0, zero and borrow asserted.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    checkOutput("resetOut",  8'(out),  8'd0);
    checkOutput("resetZero", 8'(zero), 8'd1);
    checkOutput("resetX",    8'(x),    8'd1);

    // Load 3 with z high: load wins, no decrement, no borrow.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3);
    checkOutput("load3Out",  8'(out),  8'd3);
    checkOutput("load3Zero", 8'(zero), 8'd0);
    checkOutput("load3X",    8'(x),    8'd0);

    // Count down through zero.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd3);
      checkOutput($sformatf("decOut%0d", i),  8'(out),  8'(decSeq[i]));
      checkOutput($sformatf("decZero%0d", i), 8'(zero), 8'(decSeq[i] == 4'd0));
      checkOutput($sformatf("decX%0d", i),    8'(x),    8'(decSeq[i] == 4'd0));
    end

    // Preset above the range saturates; top of range loads unchanged.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
    checkOutput("sat9Out", 8'(out), 8'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd15);
    checkOutput("sat15Out", 8'(out), 8'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
    checkOutput("load5Out", 8'(out), 8'd5);

    // Hold at 2 for five edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
    checkOutput("load2Out", 8'(out), 8'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd4);
      checkOutput($sformatf("holdOut%0d", i), 8'(out), 8'd2);
      checkOutput($sformatf("holdX%0d", i),   8'(x),   8'd0);
    end

    // Clear beats load and decrement; then load beats decrement.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
    checkOutput("prioClearOut", 8'(out), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
    checkOutput("prioLoadOut", 8'(out), 8'd4);

    // Load 1, then three decrements: stop-at-zero or wrap behaviour.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1);
    checkOutput("load1Out", 8'(out), 8'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd1);
      checkOutput($sformatf("stopOut%0d", i), 8'(out), 8'(stopSeq[i]));
      checkOutput($sformatf("stopX%0d", i),   8'(x),   8'(stopX[i]));
    end

    // Borrow follows z combinationally while the digit sits at zero.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("zeroNoZX",    8'(x),    8'd0);
    checkOutput("zeroNoZZero", 8'(zero), 8'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_timer_six
